// File: rtl/alu_result_fifo.sv
// First-word-fall-through result FIFO behind the 16-bit ALU, with sticky status.
// Optional saturating drop counter: define ALU_RESULT_FIFO_DROP_CNT_EN.
module alu_result_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           in_w,
   input  logic                       in_zer,
   input  logic                       in_neg,
   input  logic [2:0]                 in_opc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_w,
   output logic                       out_zer,
   output logic                       out_neg,
   output logic [2:0]                 out_opc,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   input  logic                       clr_sticky,
   output logic                       sticky_zer,
   output logic                       sticky_neg,
   output logic                       sticky_ovf,
   output logic [7:0]                 drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_w   [DEPTH];
   logic             mem_zer [DEPTH];
   logic             mem_neg [DEPTH];
   logic [2:0]       mem_opc [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          pop;
   logic          push;
   logic          drop;

   assign empty     = (cnt == '0);
   assign full      = (cnt == CW'(DEPTH));
   assign out_valid = !empty;
   assign count     = cnt;

   // A full FIFO still accepts when the head leaves in the same cycle.
   assign pop  = out_valid & out_ready;
   assign push = in_valid & (!full | pop);
   assign drop = in_valid & full & !pop;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_w[wr_ptr]   <= in_w;
         mem_zer[wr_ptr] <= in_zer;
         mem_neg[wr_ptr] <= in_neg;
         mem_opc[wr_ptr] <= in_opc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            cnt <= cnt + CW'(1);
         else if (pop && !push)
            cnt <= cnt - CW'(1);
      end
   end

   assign out_w   = empty ? '0   : mem_w[rd_ptr];
   assign out_zer = empty ? 1'b0 : mem_zer[rd_ptr];
   assign out_neg = empty ? 1'b0 : mem_neg[rd_ptr];
   assign out_opc = empty ? 3'd0 : mem_opc[rd_ptr];

   // Set takes priority over a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_zer <= 1'b0;
         sticky_neg <= 1'b0;
         sticky_ovf <= 1'b0;
      end else begin
         sticky_zer <= (push & in_zer) | (sticky_zer & !clr_sticky);
         sticky_neg <= (push & in_neg) | (sticky_neg & !clr_sticky);
         sticky_ovf <= drop | (sticky_ovf & !clr_sticky);
      end
   end

`ifdef ALU_RESULT_FIFO_DROP_CNT_EN
   logic [7:0] drop_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         drop_q <= 8'h00;
      else if (drop && drop_q != 8'hFF)
         drop_q <= drop_q + 8'h01;
   end

   assign drop_cnt = drop_q;
`else
   assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed + random bench for alu_result_fifo against a queue-based model.
// Honours ALU_RESULT_FIFO_DROP_CNT_EN for the expected drop counter.
module tb_alu_result_fifo;

   typedef struct packed {
      logic [15:0] w;
      logic        zer;
      logic        neg;
      logic [2:0]  opc;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_w = '0;
   logic        in_zer = 1'b0;
   logic        in_neg = 1'b0;
   logic [2:0]  in_opc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_w;
   logic        out_zer;
   logic        out_neg;
   logic [2:0]  out_opc;
   logic [2:0]  count;
   logic        full;
   logic        empty;
   logic        clr_sticky = 1'b0;
   logic        sticky_zer;
   logic        sticky_neg;
   logic        sticky_ovf;
   logic [7:0]  drop_cnt;

   int checks = 0;
   int failures = 0;

   ent_t q[$];
   bit   m_sz;
   bit   m_sn;
   bit   m_so;
   int   m_drops;

   alu_result_fifo #(.WIDTH(16), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_w(in_w),
      .in_zer(in_zer), .in_neg(in_neg),
      .in_opc(in_opc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_w(out_w), .out_zer(out_zer),
      .out_neg(out_neg), .out_opc(out_opc),
      .count(count), .full(full), .empty(empty),
      .clr_sticky(clr_sticky),
      .sticky_zer(sticky_zer), .sticky_neg(sticky_neg),
      .sticky_ovf(sticky_ovf), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      ent_t h;
      int   exp_dc;
      h = (q.size() != 0) ? q[0] : '0;
`ifdef ALU_RESULT_FIFO_DROP_CNT_EN
      exp_dc = (m_drops > 255) ? 255 : m_drops;
`else
      exp_dc = 0;
`endif
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
      chk({tag, ".out_w"}, 32'(out_w), 32'(h.w));
      chk({tag, ".out_zer"}, 32'(out_zer), 32'(h.zer));
      chk({tag, ".out_neg"}, 32'(out_neg), 32'(h.neg));
      chk({tag, ".out_opc"}, 32'(out_opc), 32'(h.opc));
      chk({tag, ".count"}, 32'(count), 32'(q.size()));
      chk({tag, ".full"}, 32'(full), 32'(q.size() == 4));
      chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
      chk({tag, ".sticky_zer"}, 32'(sticky_zer), 32'(m_sz));
      chk({tag, ".sticky_neg"}, 32'(sticky_neg), 32'(m_sn));
      chk({tag, ".sticky_ovf"}, 32'(sticky_ovf), 32'(m_so));
      chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(exp_dc));
   endtask

   task automatic step(input string tag,
                       input logic v, input logic [15:0] w,
                       input logic z, input logic n,
                       input logic [2:0] o,
                       input logic rdy, input logic clr);
      bit   p_pop;
      bit   p_push;
      bit   p_drop;
      ent_t e;
      @(negedge clk);
      in_valid = v;
      in_w = w;
      in_zer = z;
      in_neg = n;
      in_opc = o;
      out_ready = rdy;
      clr_sticky = clr;
      p_pop  = (q.size() != 0) && rdy;
      p_push = v && ((q.size() < 4) || p_pop);
      p_drop = v && (q.size() == 4) && !p_pop;
      @(posedge clk);
      #1;
      if (p_pop) void'(q.pop_front());
      if (p_push) begin
         e.w = w;
         e.zer = z;
         e.neg = n;
         e.opc = o;
         q.push_back(e);
      end
      m_sz = (p_push && z) || (m_sz && !clr);
      m_sn = (p_push && n) || (m_sn && !clr);
      m_so = p_drop || (m_so && !clr);
      if (p_drop) m_drops++;
      check_all(tag);
   endtask

   task automatic idle(input string tag, input logic rdy);
      step(tag, 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, rdy, 1'b0);
   endtask

   task automatic reset_mid(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      q.delete();
      m_sz = 0;
      m_sn = 0;
      m_so = 0;
      m_drops = 0;
      check_all(tag);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b0;
      clr_sticky = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Single push, then pop
      step("push1", 1'b1, 16'h1234, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
      idle("pop1", 1'b1);

      // Fill, drop, drain
      for (int i = 0; i < 4; i++)
         step("fill", 1'b1, 16'(16'hA000 + i), i[0], i[1], 3'(i), 1'b0, 1'b0);
      step("drop", 1'b1, 16'hDEAD, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         idle("drain", 1'b1);

      // Full with simultaneous push and pop, pointers wrap
      for (int i = 0; i < 4; i++)
         step("fill2", 1'b1, 16'(16'hB000 + i), 1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++)
         step("pushpop", 1'b1, 16'($urandom), 1'($urandom), 1'($urandom),
              3'($urandom), 1'b1, 1'b0);
      for (int i = 0; i < 4; i++)
         idle("drain2", 1'b1);

      // Sticky set / clear priority
      step("clr", 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
      step("zer", 1'b1, 16'h0000, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0);
      step("neg", 1'b1, 16'h8000, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
      step("clrneg", 1'b1, 16'hFFFF, 1'b0, 1'b1, 3'd5, 1'b1, 1'b1);
      idle("drain3", 1'b1);

      // Random traffic with a reset in the middle
      for (int i = 0; i < 200; i++) begin
         if (i == 100) reset_mid("midreset");
         step("rand", 1'($urandom_range(0, 3) != 0), 16'($urandom),
              1'($urandom), 1'($urandom), 3'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
      end

      // Drop counter saturation
      reset_mid("reset2");
      for (int i = 0; i < 4; i++)
         step("fill3", 1'b1, 16'(16'hC000 + i), 1'b0, 1'b0, 3'd6, 1'b0, 1'b0);
      for (int i = 0; i < 300; i++)
         step("sat", 1'b1, 16'($urandom), 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
      idle("final", 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
